// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: a shared bit-serial Gray-to-binary converter with a two-port
// round-robin arbiter. One word is converted at a time, MSB first, one bit per cycle.
// The binary result and the source ID leave on a single valid/ready port.
module gray_conv_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_gray,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_gray,
    output logic             req1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_src,
    output logic             busy
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            ptr;
    logic [IW-1:0]   idx;
    logic [WIDTH-1:0] g_reg;

    logic            in_idle;
    logic            grant1;
    logic            accept;
    logic            g_bit;
    logic            upper_bit;
    logic            new_bit;

    // Grant selection: a lone requester wins, otherwise the priority pointer decides.
    // Ready is gated by rst_n so that nothing is acknowledged while reset is held.
    always_comb begin
        in_idle    = (state == IDLE) && rst_n;
        grant1     = req1_valid && (!req0_valid || ptr);
        req0_ready = in_idle && req0_valid && !grant1;
        req1_ready = in_idle && grant1;
        accept     = req0_ready || req1_ready;
        out_valid  = (state == DONE);
        busy       = (state != IDLE);
    end

    // Pick the Gray bit at idx and the already-converted bit just above it.
    always_comb begin
        g_bit     = 1'b0;
        upper_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx == IW'(i)) begin
                g_bit = g_reg[i];
            end
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (idx == IW'(i)) begin
                upper_bit = out_bin[i+1];
            end
        end
        new_bit = g_bit ^ upper_bit;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, walk the bits in CONV, wait for the consumer in DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                if (idx == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch the accepted word, build the result one bit per cycle,
    // and hand priority to the other requester once a result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= 1'b0;
            idx     <= IDX_TOP;
            g_reg   <= '0;
            out_bin <= '0;
            out_src <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        g_reg   <= grant1 ? req1_gray : req0_gray;
                        out_src <= grant1;
                        out_bin <= '0;
                        idx     <= IDX_TOP;
                    end
                end
                CONV: begin
                    out_bin[idx] <= new_bit;
                    if (idx != '0) begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        ptr <= ~out_src;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed testbench for gray_conv_arbiter (WIDTH=4) with hand-computed expectations.
module tb_gray_conv_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid;
    logic [W-1:0] req0_gray;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_gray;
    logic         req1_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_bin;
    logic         out_src;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;

    gray_conv_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_gray  (req0_gray),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_gray  (req1_gray),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bin    (out_bin),
        .out_src    (out_src),
        .busy       (busy)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Hand-computed binary value for every 4-bit Gray code, indexed by the Gray code.
    logic [W-1:0] sweep_bin [16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010,
        4'b0111, 4'b0110, 4'b0100, 4'b0101,
        4'b1111, 4'b1110, 4'b1100, 4'b1101,
        4'b1000, 4'b1001, 4'b1011, 4'b1010
    };

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive both requester ports at once.
    task automatic applyStimulus(input logic v0, input logic [W-1:0] g0,
                                 input logic v1, input logic [W-1:0] g1);
        req0_valid = v0;
        req0_gray  = g0;
        req1_valid = v1;
        req1_gray  = g1;
    endtask

    // Wait, on falling edges, for out_valid with a bounded budget; n counts the edges waited.
    task automatic waitValid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("valid_wait", 16'(out_valid), 16'd1);
    endtask

    // Hold reset for two cycles and release on a falling edge.
    task automatic doReset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        logic stale;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b1, 4'b1101, 1'b1, 4'b0110);

        // Reset state, with both requesters valid to show ready is suppressed.
        #1;
        checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
        checkOutput("rst_busy", 16'(busy), 16'd0);
        checkOutput("rst_out_bin", 16'(out_bin), 16'd0);
        checkOutput("rst_out_src", 16'(out_src), 16'd0);
        checkOutput("rst_req0_ready", 16'(req0_ready), 16'd0);
        checkOutput("rst_req1_ready", 16'(req1_ready), 16'd0);
        applyStimulus(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        doReset();

        // Single request on port 0: ready pulses once, result four cycles after accept.
        applyStimulus(1'b1, 4'b1101, 1'b0, '0);
        #1;
        checkOutput("single_req0_ready", 16'(req0_ready), 16'd1);
        checkOutput("single_req1_ready", 16'(req1_ready), 16'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                applyStimulus(1'b0, '0, 1'b0, '0);
                #1;
                checkOutput("single_ready_drop", 16'(req0_ready), 16'd0);
                checkOutput("single_busy", 16'(busy), 16'd1);
            end
            checkOutput($sformatf("single_latency_k%0d", k), 16'(out_valid), (k == 5) ? 16'd1 : 16'd0);
        end
        checkOutput("single_out_bin", 16'(out_bin), 16'b1001);
        checkOutput("single_out_src", 16'(out_src), 16'd0);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("single_after_hs_valid", 16'(out_valid), 16'd0);
        checkOutput("single_after_hs_busy", 16'(busy), 16'd0);

        // Sweep all 16 Gray codes through requester 1 with out_ready tied high.
        for (int g = 0; g < 16; g++) begin
            applyStimulus(1'b0, '0, 1'b1, W'(g));
            #1;
            checkOutput($sformatf("sweep_ready_%0d", g), 16'(req1_ready), 16'd1);
            @(negedge clk);
            applyStimulus(1'b0, '0, 1'b0, '0);
            waitValid(n);
            checkOutput($sformatf("sweep_bin_%0d", g), 16'(out_bin), 16'(sweep_bin[g]));
            checkOutput($sformatf("sweep_src_%0d", g), 16'(out_src), 16'd1);
            @(negedge clk);
        end

        // Arbitration from a fresh reset with both requesters valid continuously.
        out_ready = 1'b0;
        doReset();
        out_ready = 1'b1;
        applyStimulus(1'b1, 4'b0011, 1'b1, 4'b0110);
        #1;
        checkOutput("arb_first_req0_ready", 16'(req0_ready), 16'd1);
        checkOutput("arb_first_req1_ready", 16'(req1_ready), 16'd0);
        for (int i = 0; i < 4; i++) begin
            waitValid(n);
            checkOutput($sformatf("arb_src_%0d", i), 16'(out_src), 16'(i % 2));
            checkOutput($sformatf("arb_bin_%0d", i), 16'(out_bin), (i % 2 == 0) ? 16'b0010 : 16'b0100);
            @(negedge clk);
            #1;
            if (i < 3) begin
                checkOutput($sformatf("arb_next_req0_%0d", i), 16'(req0_ready), (i % 2 == 1) ? 16'd1 : 16'd0);
                checkOutput($sformatf("arb_next_req1_%0d", i), 16'(req1_ready), (i % 2 == 0) ? 16'd1 : 16'd0);
            end
        end
        applyStimulus(1'b0, '0, 1'b0, '0);

        // Backpressure: result held for ten cycles while both requesters knock.
        out_ready = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 4'b1010, 1'b0, '0);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, '0);
        waitValid(n);
        applyStimulus(1'b1, 4'b0101, 1'b1, 4'b0011);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_valid_%0d", k), 16'(out_valid), 16'd1);
            checkOutput($sformatf("bp_bin_%0d", k), 16'(out_bin), 16'b1100);
            checkOutput($sformatf("bp_src_%0d", k), 16'(out_src), 16'd0);
            checkOutput($sformatf("bp_busy_%0d", k), 16'(busy), 16'd1);
            checkOutput($sformatf("bp_req0_ready_%0d", k), 16'(req0_ready), 16'd0);
            checkOutput($sformatf("bp_req1_ready_%0d", k), 16'(req1_ready), 16'd0);
        end
        applyStimulus(1'b0, '0, 1'b0, '0);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_valid", 16'(out_valid), 16'd0);
        checkOutput("bp_release_busy", 16'(busy), 16'd0);
        out_ready = 1'b0;

        // Reset in the middle of a conversion from requester 1.
        applyStimulus(1'b0, '0, 1'b1, 4'b1111);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("midconv_busy", 16'(busy), 16'd1);
        applyStimulus(1'b1, 4'b0011, 1'b1, 4'b0110);
        rst_n = 1'b0;
        #1;
        checkOutput("midconv_rst_valid", 16'(out_valid), 16'd0);
        checkOutput("midconv_rst_busy", 16'(busy), 16'd0);
        checkOutput("midconv_rst_bin", 16'(out_bin), 16'd0);
        checkOutput("midconv_rst_src", 16'(out_src), 16'd0);
        checkOutput("midconv_rst_req0_ready", 16'(req0_ready), 16'd0);
        checkOutput("midconv_rst_req1_ready", 16'(req1_ready), 16'd0);
        applyStimulus(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            stale = stale | out_valid | busy;
        end
        checkOutput("midconv_no_stale", 16'(stale), 16'd0);
        applyStimulus(1'b1, 4'b0011, 1'b1, 4'b0110);
        #1;
        checkOutput("midconv_dual_req0_ready", 16'(req0_ready), 16'd1);
        checkOutput("midconv_dual_req1_ready", 16'(req1_ready), 16'd0);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, '0);
        waitValid(n);
        checkOutput("midconv_dual_src", 16'(out_src), 16'd0);
        checkOutput("midconv_dual_bin", 16'(out_bin), 16'b0010);
        @(negedge clk);

        // Requester 1 alone, three words back to back, each accepted right after the handshake.
        for (int i = 0; i < 3; i++) begin
            logic [W-1:0] g;
            logic [W-1:0] b;
            case (i)
                0: begin g = 4'b0111; b = 4'b0101; end
                1: begin g = 4'b0101; b = 4'b0110; end
                default: begin g = 4'b1100; b = 4'b1000; end
            endcase
            applyStimulus(1'b0, '0, 1'b1, g);
            #1;
            checkOutput($sformatf("repeat_ready_%0d", i), 16'(req1_ready), 16'd1);
            @(negedge clk);
            applyStimulus(1'b0, '0, 1'b0, '0);
            waitValid(n);
            checkOutput($sformatf("repeat_latency_%0d", i), 16'(n), 16'd4);
            checkOutput($sformatf("repeat_bin_%0d", i), 16'(out_bin), 16'(b));
            checkOutput($sformatf("repeat_src_%0d", i), 16'(out_src), 16'd1);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

Shared Gray-to-binary conversion engine with a two-port round-robin arbiter. Two requesters submit Gray-coded words over valid/ready handshakes. The block grants one requester at a time and converts the word bit-serially, MSB first, one bit per cycle. It then presents the binary result plus the source ID on a single valid/ready output port. It sits between Gray-coded sources (counters, position encoders) and binary consumers, replacing per-source combinational converters.

## Interface
- WIDTH, 4, word width in bits; must be ≥ 2.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req0_valid  input  1  requester 0 has a word.
- req0_gray  input  WIDTH  requester 0 Gray word.
- req0_ready  output  1  requester 0 word accepted this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_gray  input  WIDTH  requester 1 Gray word.
- req1_ready  output  1  requester 1 word accepted this cycle.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_bin  output  WIDTH  binary result.
- out_src  output  1  ID of the requester that supplied the word (0/1).
- busy  output  1  high in the CONV and DONE states.

## Operation
- The FSM has three states: IDLE, CONV and DONE.
- IDLE: if any reqN_valid, grant one requester:
  - If only one requester is valid, grant it.
  - If both are valid, grant the one selected by the priority pointer `ptr`.
- reqN_ready is combinational: high only in IDLE and only for the granted requester. A handshake is reqN_valid & reqN_ready.
- On a handshake:
  - Latch the Gray word into `g_reg` and the source ID into `out_src`.
  - Clear `out_bin`, set bit index `idx`=WIDTH-1, go to CONV.
- CONV, one bit per cycle:
  - Compute `out_bin[idx]` = g_reg[idx] XOR (idx==WIDTH-1 ? 0 : out_bin[idx+1]).
  - When idx==0, go to DONE. Otherwise decrement idx.
- DONE: out_valid=1. `out_bin` and `out_src` are held stable until out_ready.
- On the output handshake:
  - Go to IDLE.
  - Set ptr = ~out_src, so the other requester gets priority next.
- No request is accepted outside IDLE. Both reqN_ready stay low in CONV and DONE.
- Result definition: out_bin[i] = XOR of g_reg[WIDTH-1:i].

## Timing
- Reset (rst_n low, asynchronous) forces the following, immediately and independent of clk:
  - state=IDLE, ptr=0, idx=WIDTH-1.
  - g_reg=0, out_bin=0, out_src=0, out_valid=0, busy=0.
  - req0_ready=0 and req1_ready=0 while in reset.
- Reset mid-CONV or mid-DONE discards the word in flight; no out_valid is produced for it.
- Accept handshake at edge E:
  - CONV occupies cycles E+1 … E+WIDTH.
  - out_valid rises after edge E+WIDTH, so latency is WIDTH cycles from accept to out_valid.
- Output handshake at edge F:
  - State is IDLE after F, and out_valid is low after F.
  - The earliest next accept is edge F+1.
- Minimum period per result is WIDTH+2 cycles.
- Backpressure: while out_valid=1 and out_ready=0, out_bin and out_src do not change and busy stays high.
- Simultaneous valid: arbitration uses the ptr value in the IDLE cycle. Under continuous dual requests, grants alternate 0,1,0,1…
- out_ready asserted outside DONE has no effect.

## Test plan
- Single request, WIDTH=4: req0_gray=4'b1101 → req0_ready pulses one cycle; out_valid 4 cycles after accept; out_bin=4'b1001, out_src=0.
- Exhaustive sweep on req1: all 16 Gray codes, out_ready tied high → each out_bin equals the XOR-prefix model; 1000→1111, 0000→0000, 0001→0001; out_src=1.
- Arbitration after reset, both valid continuously:
  - req0=4'b0011, req1=4'b0110 → results come out in order src 0 (0010), src 1 (0100), src 0, src 1…
  - No requester is granted twice in a row.
- Backpressure: hold out_ready=0 for 10 cycles during DONE →
  - out_valid, out_bin and out_src stay stable; busy stays 1.
  - Both reqN_ready stay 0.
  - out_ready=1 → handshake, IDLE next cycle.
- Reset mid-CONV: assert rst_n=0 at cycle 2 of CONV →
  - All outputs go to 0 asynchronously.
  - After release, no stale out_valid appears.
  - A subsequent dual request is granted to req0 (ptr=0).
- Single requester repeat: req1 valid only, three words 0111, 0101, 1100 → results 0101, 0110, 1000, all src 1, each accepted at F+1 after the previous output handshake.
